// File: rtl/key_ctl_multi.sv
// key_ctl_multi: N independent push-button channels. Each channel has a
// two-flop synchroniser, a counter debouncer, a short/long press classifier
// and a wrapping mode register. All outputs are registered.
`timescale 1ns/1ps
module key_ctl_multi #(
    parameter int N_KEYS          = 2,
    parameter int KEY_ACTIVE      = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 200,
    parameter int N_MODES         = 4,
    parameter int MODE_W          = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_KEYS-1:0]          key,
    output logic [N_KEYS-1:0]          key_stable,
    output logic [N_KEYS-1:0]          short_pulse,
    output logic [N_KEYS-1:0]          long_pulse,
    output logic [N_KEYS*MODE_W-1:0]   ctrl
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    // Threshold is tested on the current count so the pulse flop and the
    // counter reaching LONG_CYCLES-1 land on the same edge.
    localparam logic [HOLD_W-1:0] HOLD_LONG  = HOLD_W'(LONG_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(N_MODES - 1);

    // Raw pin level of a released key.
    localparam logic KEY_RELEASED = (KEY_ACTIVE == 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_LONG_HELD = 2'd2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic                sync1_q, sync1_d;
        logic                sync2_q, sync2_d;
        logic                synced;
        logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
        logic                stable_q, stable_d;
        logic [1:0]          state_q, state_d;
        logic [HOLD_W-1:0]   hold_q, hold_d;
        logic                short_q, short_d;
        logic                long_q, long_d;
        logic [MODE_W-1:0]   mode_q, mode_d;

        // Normalise the synchronised level so that 1 always means pressed.
        assign synced = ~(sync2_q ^ ~KEY_RELEASED);

        // Synchroniser chain and debounce counter: accept a level only after it
        // has disagreed with key_stable for DEBOUNCE_CYCLES consecutive cycles.
        always_comb begin
            // NOTE: combinational blocks use blocking '=' and assign every
            // output a default first, so no path can leave a latch behind.
            sync1_d  = key[i];
            sync2_d  = sync1_q;
            stable_d = stable_q;
            db_cnt_d = '0;
            if (synced != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = synced;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Press classifier: short on release before the hold threshold, long
        // once the threshold is reached; the threshold wins a same-cycle tie.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            short_d = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (stable_q) begin
                        state_d = ST_PRESSED;
                        hold_d  = '0;
                    end
                end
                ST_PRESSED: begin
                    hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                    if (hold_q == HOLD_LONG) begin
                        long_d  = 1'b1;
                        state_d = ST_LONG_HELD;
                    end else if (!stable_q) begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_LONG_HELD: begin
                    if (!stable_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Mode register changes on the same edge that raises its pulse.
        always_comb begin
            mode_d = mode_q;
            if (long_d) begin
                mode_d = '0;
            end else if (short_d) begin
                mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
            end
        end

        // State registers with synchronous reset to the released condition.
        always_ff @(posedge clk) begin
            // NOTE: reset is sampled on the clock edge like any other input,
            // and registers use non-blocking '<=' so all update together.
            if (rst) begin
                sync1_q  <= KEY_RELEASED;
                sync2_q  <= KEY_RELEASED;
                db_cnt_q <= '0;
                stable_q <= 1'b0;
                state_q  <= ST_IDLE;
                hold_q   <= '0;
                short_q  <= 1'b0;
                long_q   <= 1'b0;
                mode_q   <= '0;
            end else begin
                sync1_q  <= sync1_d;
                sync2_q  <= sync2_d;
                db_cnt_q <= db_cnt_d;
                stable_q <= stable_d;
                state_q  <= state_d;
                hold_q   <= hold_d;
                short_q  <= short_d;
                long_q   <= long_d;
                mode_q   <= mode_d;
            end
        end

        assign key_stable[i]                = stable_q;
        assign short_pulse[i]               = short_q;
        assign long_pulse[i]                = long_q;
        assign ctrl[i*MODE_W +: MODE_W]     = mode_q;
    end

endmodule

// File: tb/tb_key_ctl_multi.sv
// tb_key_ctl_multi: directed stimulus; expected pulses are queued per key when
// a press is issued and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_key_ctl_multi;

    localparam int LAT       = 18;          // raw edge -> key_stable edge
    localparam int L_CYC     = 200;
    localparam int LONG_OFS  = LAT + L_CYC; // raw press -> long pulse
    localparam int SHORT_OFS = LAT + 1;     // raw release -> short pulse

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b00;
    logic [1:0] key_stable, short_pulse, long_pulse;
    logic [3:0] ctrl;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        bit         is_long;
        logic [1:0] mode;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    key_ctl_multi dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_stable  (key_stable),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .ctrl        (ctrl)
    );

    always #1 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input bit lng, input logic [1:0] mode);
        exp_t e;
        e.cyc = c;
        e.is_long = lng;
        e.mode = mode;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One press on key k held for 'hold' raw cycles, with the expected pulse
    // and resulting mode queued; optionally checks the debounce latency.
    task automatic press(input int k, input int hold, input bit lng,
                         input logic [1:0] mode, input bit chk_rise);
        int n;
        @(negedge clk);
        key[k] = 1'b1;
        n = cyc;
        if (lng) push(k, n + LONG_OFS, 1'b1, mode);
        if (chk_rise) begin
            repeat (LAT - 1) @(negedge clk);
            check("stable_before_latency", key_stable[k], 0);
            @(negedge clk);
            check("stable_at_latency", key_stable[k], 1);
            repeat (hold - LAT) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
        key[k] = 1'b0;
        if (!lng) push(k, cyc + SHORT_OFS, 1'b0, mode);
        repeat (40) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of its key's queue.
    exp_t mon_e;
    bit   mon_have;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (short_pulse[k] || long_pulse[k]) begin
                check($sformatf("pulse_exclusive_k%0d", k), short_pulse[k] & long_pulse[k], 0);
                mon_have = 1'b0;
                if (k == 0 && q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    mon_have = 1'b1;
                end else if (k == 1 && q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    mon_have = 1'b1;
                end
                check($sformatf("pulse_expected_k%0d", k), mon_have, 1);
                if (mon_have) begin
                    check($sformatf("pulse_cycle_k%0d", k), cyc, mon_e.cyc);
                    check($sformatf("pulse_kind_long_k%0d", k), long_pulse[k], mon_e.is_long);
                    check($sformatf("pulse_mode_k%0d", k), ctrl[k*2 +: 2], mon_e.mode);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic bounce_seen;
    int   r;

    initial begin
        // Reset with both keys held: outputs stay 0, then both debounce.
        @(negedge clk);
        key = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("reset_outputs", {key_stable, short_pulse, long_pulse, ctrl}, 0);
        end
        rst = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("t1_stable_before", key_stable, 2'b00);
        @(negedge clk);
        check("t1_stable_at_latency", key_stable, 2'b11);
        repeat (42) @(negedge clk);
        key = 2'b00;
        push(0, cyc + SHORT_OFS, 1'b0, 2'd1);
        push(1, cyc + SHORT_OFS, 1'b0, 2'd1);
        repeat (40) @(negedge clk);
        check("t1_ctrl", ctrl, 4'b0101);

        // Bounce rejection: 10 high, 5 low, 12 high, all under the threshold.
        bounce_seen = 1'b0;
        key[0] = 1'b1;
        repeat (10) begin @(negedge clk); bounce_seen |= key_stable[0]; end
        key[0] = 1'b0;
        repeat (5)  begin @(negedge clk); bounce_seen |= key_stable[0]; end
        key[0] = 1'b1;
        repeat (12) begin @(negedge clk); bounce_seen |= key_stable[0]; end
        key[0] = 1'b0;
        repeat (20) begin @(negedge clk); bounce_seen |= key_stable[0]; end
        check("t2_no_stable_change", bounce_seen, 0);
        check("t2_ctrl_unchanged", ctrl, 4'b0101);

        // Short press on key 0: mode 1 -> 2.
        press(0, 100, 1'b0, 2'd2, 1'b1);

        // Wrap on key 1: mode 1 -> 2 -> 3 -> 0 -> 1.
        press(1, 40, 1'b0, 2'd2, 1'b0);
        press(1, 40, 1'b0, 2'd3, 1'b0);
        press(1, 40, 1'b0, 2'd0, 1'b0);
        press(1, 40, 1'b0, 2'd1, 1'b0);

        // Long press on key 0: mode 2 -> 0, no short on release.
        press(0, 540, 1'b1, 2'd0, 1'b1);

        // Threshold boundary: 198 raw cycles is short, 199 ties and is long.
        press(0, 198, 1'b0, 2'd1, 1'b0);
        press(0, 199, 1'b1, 2'd0, 1'b0);

        // Concurrency: key 1 long press overlapping a key 0 short press.
        fork
            press(1, 300, 1'b1, 2'd0, 1'b0);
            begin
                repeat (20) @(negedge clk);
                press(0, 80, 1'b0, 2'd1, 1'b0);
            end
        join
        check("t6_ctrl", ctrl, 4'b0001);

        // Reset while key 0 is held at hold count 150; fresh press afterwards.
        @(negedge clk);
        key[0] = 1'b1;
        repeat (169) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_reset_outputs", {key_stable, short_pulse, long_pulse, ctrl}, 0);
        end
        rst = 1'b0;
        r = cyc;
        repeat (LAT - 1) @(negedge clk);
        check("t6_restable_before", key_stable[0], 0);
        @(negedge clk);
        check("t6_restable_at_latency", key_stable[0], 1);
        repeat (100 - LAT) @(negedge clk);
        key[0] = 1'b0;
        push(0, cyc + SHORT_OFS, 1'b0, 2'd1);
        repeat (40) @(negedge clk);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("final_ctrl", ctrl, 4'b0001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
